// File: rtl/demux1x8_deserializer.sv
// Serial-to-parallel receiver: steers each accepted bit into its slot and presents completed words on a registered valid/ready slot.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing even-parity bit per frame and a registered parity_err).
module demux1x8_deserializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
`ifdef PARITY_CHECK_EN
    localparam int FRAME    = WIDTH + 1,
`else
    localparam int FRAME    = WIDTH,
`endif
    localparam int SEL_W    = $clog2(FRAME)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s_in,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic [SEL_W-1:0] sel,
    output logic             parity_err
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the source holds its data while valid && !ready.

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(FRAME - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_LAST = 1'b1
    } state_t;

    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] r_pout;
    logic             r_pvalid;
    state_t           w_state;
    logic             w_accept;
    logic [WIDTH-1:0] w_next_asm;

    // The control state lives entirely in sel; sel is the visible state.
    assign w_state  = (r_sel == LAST_SEL) ? ST_LAST : ST_FILL;
    assign s_ready  = !clr && !(w_state == ST_LAST && r_pvalid && !p_ready);
    assign w_accept = s_valid && s_ready;

    // With parity enabled the final slot matches no data index, so the
    // parity bit never lands in the assembled word.
    always_comb begin
        w_next_asm = r_asm;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_next_asm[(MSB_FIRST != 0) ? (WIDTH - 1 - i) : i] = s_in;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic r_perr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= '0;
            r_asm    <= '0;
            r_pout   <= '0;
            r_pvalid <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_perr   <= 1'b0;
`endif
        end else begin
            // A drain is overridden below when a new word loads on the same edge.
            if (r_pvalid && p_ready) begin
                r_pvalid <= 1'b0;
            end
            if (clr) begin
                r_sel <= '0;
                r_asm <= '0;
            end else if (w_accept) begin
                if (w_state == ST_LAST) begin
                    r_sel    <= '0;
                    r_asm    <= '0;
                    r_pout   <= w_next_asm;
                    r_pvalid <= 1'b1;
`ifdef PARITY_CHECK_EN
                    r_perr   <= ^{r_asm, s_in};
`endif
                end else begin
                    r_sel <= r_sel + 1'b1;
                    r_asm <= w_next_asm;
                end
            end
        end
    end

    assign sel     = r_sel;
    assign p_out   = r_pout;
    assign p_valid = r_pvalid;
`ifdef PARITY_CHECK_EN
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux1x8_deserializer.sv
// Directed bench for demux1x8_deserializer: LSB/MSB ordering, backpressure, clear, async reset, optional parity.
module tb_demux1x8_deserializer;

    localparam int WIDTH = 8;
`ifdef PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int SEL_W = $clog2(FRAME);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             s_in;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] p_out;
    logic             p_valid;
    logic             p_ready;
    logic [SEL_W-1:0] sel;
    logic             parity_err;

    logic             m_s_ready;
    logic [WIDTH-1:0] m_p_out;
    logic             m_p_valid;
    logic [SEL_W-1:0] m_sel;
    logic             m_parity_err;

    int n_checks = 0;
    int n_errors = 0;

    demux1x8_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_in(s_in), .s_valid(s_valid),
        .s_ready(s_ready), .p_out(p_out), .p_valid(p_valid), .p_ready(p_ready),
        .sel(sel), .parity_err(parity_err)
    );

    // Mirror-ordered instance fed the same stream; only its first word is checked.
    demux1x8_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_in(s_in), .s_valid(s_valid),
        .s_ready(m_s_ready), .p_out(m_p_out), .p_valid(m_p_valid), .p_ready(p_ready),
        .sel(m_sel), .parity_err(m_parity_err)
    );

    // Clock: rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        s_valid = 1'b1;
        s_in    = b;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_in    = 1'b0;
    endtask

    // Sends bits 0..n-1 of {par, w}, LSB first.
    task automatic send_frame(input logic [7:0] w, input logic par, input int n);
        logic [8:0] f;
        f = {par, w};
        for (int i = 0; i < n; i++) send_bit(f[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; s_in = 1'b0; s_valid = 1'b0; p_ready = 1'b1;

        // Reset state
        #12;
        check("rst_sel", 16'(sel), 16'h0);
        check("rst_p_valid", 16'(p_valid), 16'h0);
        check("rst_p_out", 16'(p_out), 16'h0);
        check("rst_parity_err", 16'(parity_err), 16'h0);
        #5 rst_n = 1'b1;
        #1;
        check("rel_s_ready", 16'(s_ready), 16'h1);
        @(posedge clk); #1;

        // LSB-first 1,0,0,1,0,0,1,1 -> 0xC9; MSB-first instance -> 0x93
        send_frame(8'hC9, 1'b0, FRAME);
        check("w1_p_valid", 16'(p_valid), 16'h1);
        check("w1_p_out", 16'(p_out), 16'hC9);
        check("w1_msb_p_out", 16'(m_p_out), 16'h93);
        check("w1_sel_wrap", 16'(sel), 16'h0);
        check("w1_parity_err", 16'(parity_err), 16'h0);
        idle(1);
        check("w1_drained", 16'(p_valid), 16'h0);

        // Backpressure: slot full, second word stalls on its final bit
        p_ready = 1'b0;
        send_frame(8'hC9, 1'b0, FRAME);
        check("bp_w1_p_out", 16'(p_out), 16'hC9);
        send_frame(8'h3C, 1'b0, FRAME - 1);
        check("bp_sel_last", 16'(sel), 16'(FRAME - 1));
        s_valid = 1'b1; s_in = 1'b0;
        #1;
        check("bp_s_ready_low", 16'(s_ready), 16'h0);
        @(posedge clk); #1;
        check("bp_sel_held", 16'(sel), 16'(FRAME - 1));
        check("bp_p_out_held", 16'(p_out), 16'hC9);
        check("bp_p_valid_held", 16'(p_valid), 16'h1);
        p_ready = 1'b1;
        #1;
        check("bp_s_ready_comb", 16'(s_ready), 16'h1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("bp_w2_p_out", 16'(p_out), 16'h3C);
        check("bp_w2_p_valid", 16'(p_valid), 16'h1);
        check("bp_w2_sel", 16'(sel), 16'h0);
        idle(1);
        check("bp_w2_drained", 16'(p_valid), 16'h0);

        // Clear after 3 bits, then a full 0xA5
        send_frame(8'hFF, 1'b0, 3);
        check("clr_sel_before", 16'(sel), 16'h3);
        clr = 1'b1; s_valid = 1'b1; s_in = 1'b1;
        #1;
        check("clr_s_ready_low", 16'(s_ready), 16'h0);
        @(posedge clk); #1;
        clr = 1'b0; s_valid = 1'b0;
        check("clr_sel_zero", 16'(sel), 16'h0);
        check("clr_no_word", 16'(p_valid), 16'h0);
        send_frame(8'hA5, 1'b0, FRAME);
        check("clr_a5_p_out", 16'(p_out), 16'hA5);
        check("clr_a5_p_valid", 16'(p_valid), 16'h1);
        idle(1);

        // Clear on the frame-final bit wins: no word produced
        send_frame(8'h0F, 1'b0, FRAME - 1);
        clr = 1'b1; s_valid = 1'b1; s_in = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; s_valid = 1'b0;
        check("clr_final_no_word", 16'(p_valid), 16'h0);
        check("clr_final_p_out_kept", 16'(p_out), 16'hA5);
        check("clr_final_sel", 16'(sel), 16'h0);

        // Asynchronous reset mid-frame with a pending word
        p_ready = 1'b0;
        send_frame(8'hC9, 1'b0, FRAME);
        send_frame(8'hFF, 1'b0, 5);
        check("arst_sel_before", 16'(sel), 16'h5);
        check("arst_p_valid_before", 16'(p_valid), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", 16'(sel), 16'h0);
        check("arst_p_valid", 16'(p_valid), 16'h0);
        check("arst_p_out", 16'(p_out), 16'h0);
        check("arst_parity_err", 16'(parity_err), 16'h0);
        #3 rst_n = 1'b1;
        p_ready = 1'b1;
        idle(2);
        check("arst_no_spurious", 16'(p_valid), 16'h0);
        check("arst_sel_after", 16'(sel), 16'h0);
        check("arst_s_ready_after", 16'(s_ready), 16'h1);

`ifdef PARITY_CHECK_EN
        // 0xC9 has four ones: even parity bit is 0
        send_frame(8'hC9, 1'b1, FRAME);
        check("par_bad_p_out", 16'(p_out), 16'hC9);
        check("par_bad_err", 16'(parity_err), 16'h1);
        idle(1);
        send_frame(8'hC9, 1'b0, FRAME);
        check("par_ok_p_out", 16'(p_out), 16'hC9);
        check("par_ok_err", 16'(parity_err), 16'h0);
        idle(1);
`else
        send_frame(8'h01, 1'b0, FRAME);
        check("nopar_p_out", 16'(p_out), 16'h01);
        check("nopar_err_tied", 16'(parity_err), 16'h0);
        idle(1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
